// File: rtl/gear_input_conditioner_if.sv
// Raw button inputs and conditioned shift/brake requests between the panel and the gearbox FSM.
interface gear_input_conditioner_if;
  logic btn_up_raw;
  logic btn_down_raw;
  logic btn_brake_raw;
  logic shift_up;
  logic shift_down;
  logic brake;
  logic conflict;

  modport master (
    output btn_up_raw,
    output btn_down_raw,
    output btn_brake_raw,
    input  shift_up,
    input  shift_down,
    input  brake,
    input  conflict
  );

  modport slave (
    input  btn_up_raw,
    input  btn_down_raw,
    input  btn_brake_raw,
    output shift_up,
    output shift_down,
    output brake,
    output conflict
  );
endinterface

// File: rtl/gear_input_conditioner.sv
// Synchronizes and debounces the gear buttons and brake switch, and turns them into
// single-cycle shift requests with hold-repeat, brake inhibit of up-shifts and conflict dropping.
module gear_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250,
  parameter int unsigned REPEAT_CYCLES   = 12500
) (
  input logic                     clk,
  input logic                     reset,
  gear_input_conditioner_if.slave bus
);

  localparam int unsigned CW  = 16;
  localparam int unsigned NCH = 3;
  localparam int unsigned NSH = 2;
  localparam int unsigned UP  = 0;
  localparam int unsigned DN  = 1;
  localparam int unsigned BK  = 2;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
  localparam bit            REP_EN   = (REPEAT_CYCLES != 0);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] db;
  logic [NCH-1:0] db_next_c;
  logic [CW-1:0]  cnt      [NCH];
  logic [CW-1:0]  cnt_next_c [NCH];

  logic [CW-1:0]  rep      [NSH];
  logic [CW-1:0]  rep_next_c [NSH];
  logic [NSH-1:0] rep_fire_c;
  logic [NSH-1:0] rise_c;

  logic cand_up_c;
  logic cand_dn_c;
  logic up_ok_c;
  logic brake_inhibit_c;

  logic shift_up_q;
  logic shift_dn_q;
  logic conflict_q;

  assign raw = {bus.btn_brake_raw, bus.btn_down_raw, bus.btn_up_raw};

  // Two-flop synchronizers; only sync2 is used downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a level is accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      db_next_c[i]  = db[i];
      cnt_next_c[i] = '0;
      if (sync2[i] != db[i]) begin
        if (cnt[i] == DB_LAST) begin
          db_next_c[i] = sync2[i];
        end else begin
          cnt_next_c[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      db <= db_next_c;
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= cnt_next_c[i];
      end
    end
  end

  assign rise_c = db_next_c[NSH-1:0] & ~db[NSH-1:0];

  // Hold-repeat runs only while the button stays accepted; a release edge never fires.
  always_comb begin
    for (int i = 0; i < NSH; i++) begin
      rep_fire_c[i] = 1'b0;
      rep_next_c[i] = '0;
      if (db[i] && db_next_c[i]) begin
        if (REP_EN && (rep[i] == REP_LAST)) begin
          rep_fire_c[i] = 1'b1;
        end else begin
          rep_next_c[i] = rep[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NSH; i++) begin
        rep[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NSH; i++) begin
        rep[i] <= rep_next_c[i];
      end
    end
  end

  // Up requests are inhibited while braking, including the edge the brake is accepted.
  assign cand_up_c       = rise_c[UP] | rep_fire_c[UP];
  assign cand_dn_c       = rise_c[DN] | rep_fire_c[DN];
  assign brake_inhibit_c = db[BK] | db_next_c[BK];
  assign up_ok_c         = cand_up_c & ~brake_inhibit_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_up_q <= 1'b0;
      shift_dn_q <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      shift_up_q <= up_ok_c & ~cand_dn_c;
      shift_dn_q <= cand_dn_c & ~up_ok_c;
      conflict_q <= up_ok_c & cand_dn_c;
    end
  end

  assign bus.shift_up   = shift_up_q;
  assign bus.shift_down = shift_dn_q;
  assign bus.conflict   = conflict_q;
  assign bus.brake      = db[BK];

endmodule

// File: doc/gear_input_conditioner.md
GEAR_INPUT_CONDITIONER -- requirements
Module: gear_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250 (10 ms at 25 kHz), consecutive stable cycles required to accept a level change; legal range 1..65535.
REQ-002 Parameter REPEAT_CYCLES, default 12500 (0.5 s), cycle period of hold-repeat shift pulses; 0 disables repeat; legal range 0..65535.
REQ-003 clk  input  1  system clock (25 kHz); all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_up_raw  input  1  asynchronous shift-up button, active high.
REQ-006 btn_down_raw  input  1  asynchronous shift-down button, active high.
REQ-007 btn_brake_raw  input  1  asynchronous brake switch, active high.
REQ-008 shift_up  output  1  registered single-cycle shift-up request to the gearbox FSM.
REQ-009 shift_down  output  1  registered single-cycle shift-down request to the gearbox FSM.
REQ-010 brake  output  1  registered debounced brake level.
REQ-011 conflict  output  1  registered single-cycle flag: simultaneous up/down requests were dropped.

Function
REQ-012 Each raw input SHALL pass through its own two-flop synchronizer; only the second flop (sync2) feeds later logic.
REQ-013 Each channel SHALL hold a debounced level db and a 16-bit counter cnt.
REQ-014 At each edge: if sync2 == db, cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1, db <= sync2 and cnt <= 0; else cnt <= cnt+1.
REQ-015 Timing: edge 0 = first edge sampling raw high, raw held high thereafter; db goes high after edge DEBOUNCE_CYCLES+1.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave db unchanged and clear cnt.
REQ-017 brake SHALL equal brake-channel db (no extra latency).
REQ-018 Candidate up event on the edge where up db goes 0->1; likewise for down.
REQ-019 Repeat counter per shift channel: cleared when db is 0 or an event fires; increments while db is 1; when REPEAT_CYCLES != 0 and counter reaches REPEAT_CYCLES-1, another candidate event fires and counter clears.
REQ-020 shift_up SHALL be high for exactly the cycle following an edge with an up candidate, unless suppressed.
REQ-021 Up candidates SHALL be discarded (not delayed) while brake db is 1, and on the same edge brake db goes 0->1.
REQ-022 Down candidates SHALL never be suppressed by brake.
REQ-023 If up and down candidates (after REQ-021) fall on the same edge, both SHALL be discarded and conflict asserted for the next cycle only.
REQ-024 shift_up and shift_down SHALL never be high in the same cycle; each is at most one cycle wide per candidate.
REQ-025 Releasing a button SHALL produce no pulse; release debounces per REQ-014 and stops repeat.

Reset
REQ-026 While reset is high at an edge, all synchronizer flops, db, cnt, repeat counters and all outputs SHALL load 0.
REQ-027 Reset mid-debounce or mid-repeat SHALL discard progress; a button held through reset release SHALL be re-debounced from zero and produce a fresh pulse per REQ-015.
REQ-028 reset SHALL take priority over all inputs; outputs are 0 in the cycle after any reset edge.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10 unless stated)
REQ-029 Up raised at edge 0, held -> db_up high after edge 5, shift_up high only in cycle after edge 5, repeats after edges 15, 25 while held.
REQ-030 Down raw pulse of 3 cycles -> no shift_down, cnt returns 0; 4+ cycles -> exactly one shift_down.
REQ-031 Brake held debounced, up pressed -> shift_up stays 0, brake=1; down pressed -> shift_down pulses normally.
REQ-032 Up and down raised at same edge -> shift_up=0, shift_down=0, conflict=1 for one cycle after edge 5.
REQ-033 Up held, reset at edge 3 for 1 cycle, released -> no pulse before reset; shift_up high only in cycle after 6th edge post-release (edge 0 = first post-reset sample).
REQ-034 REPEAT_CYCLES=0, up held 100 cycles -> exactly one shift_up.
